// File: rtl/cpu_defs.sv
// Shared TLB types: index/entry types, op encoding, EntryHi/EntryLo field offsets and
// pack/unpack helpers between CP0 register words and the packed TLB entry.
package cpu_defs;

  localparam int unsigned TlbEntriesDef = 16;
  localparam int unsigned TlbIdxW       = $clog2(TlbEntriesDef);

  typedef logic [TlbIdxW-1:0] tlb_index_t;

  typedef enum logic [1:0] {
    OpTlbr  = 2'b00,
    OpTlbwi = 2'b01,
    OpTlbwr = 2'b10,
    OpTlbp  = 2'b11
  } tlb_op_t;

  localparam int unsigned HiVpn2Lsb = 13;
  localparam int unsigned HiAsidLsb = 0;
  localparam int unsigned LoPfnLsb  = 6;
  localparam int unsigned LoCLsb    = 3;
  localparam int unsigned LoDBit    = 2;
  localparam int unsigned LoVBit    = 1;
  localparam int unsigned LoGBit    = 0;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  // A TLB entry is global only if both halves are marked global.
  function automatic tlb_entry_t pack_entry(input logic [31:0] hi, input logic [31:0] lo0,
                                            input logic [31:0] lo1);
    tlb_entry_t e;
    e.vpn2 = hi[HiVpn2Lsb +: 19];
    e.asid = hi[HiAsidLsb +: 8];
    e.g    = lo0[LoGBit] & lo1[LoGBit];
    e.pfn0 = lo0[LoPfnLsb +: 20];
    e.c0   = lo0[LoCLsb +: 3];
    e.d0   = lo0[LoDBit];
    e.v0   = lo0[LoVBit];
    e.pfn1 = lo1[LoPfnLsb +: 20];
    e.c1   = lo1[LoCLsb +: 3];
    e.d1   = lo1[LoDBit];
    e.v1   = lo1[LoVBit];
    return e;
  endfunction

  function automatic logic [31:0] hi_word(input logic [18:0] vpn2, input logic [7:0] asid);
    return {vpn2, 5'b0, asid};
  endfunction

  function automatic logic [31:0] lo_word(input logic [19:0] pfn, input logic [2:0] c,
                                          input logic d, input logic v, input logic g);
    return {6'b0, pfn, c, d, v, g};
  endfunction

endpackage

// File: rtl/tlb_random_reg.sv
// CP0 Random register: free-running down-counter that wraps to the top entry at Wired
// and reloads whenever Wired is written.
module tlb_random_reg #(
  parameter int unsigned TLB_ENTRIES = 16,
  parameter int unsigned IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] wired,
  input  logic             wired_we,
  output logic [IDX_W-1:0] random
);

  localparam logic [IDX_W-1:0] TopIdx = IDX_W'(TLB_ENTRIES - 1);

  logic [IDX_W-1:0] random_q, random_d;

  // Using <= on the wrap test keeps Random at or above Wired even if Wired moves up.
  always_comb begin
    random_d = random_q - IDX_W'(1);
    if (wired_we || (random_q <= wired) || (wired >= TopIdx)) begin
      random_d = TopIdx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      random_q <= TopIdx;
    end else begin
      random_q <= random_d;
    end
  end

  assign random = random_q;

endmodule

// File: rtl/tlb_op_unit.sv
// TLB maintenance initiator: runs TLBR/TLBWI/TLBWR/TLBP against the MMU and returns
// CP0 writeback data plus a pipeline flush request for TLB-changing ops.
module tlb_op_unit
  import cpu_defs::*;
#(
  parameter int unsigned TLB_ENTRIES = TlbEntriesDef,
  parameter int unsigned IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [1:0]       op_type,
  output logic             op_ready,
  input  logic [31:0]      cp0_index,
  input  logic [31:0]      cp0_entry_hi,
  input  logic [31:0]      cp0_entry_lo0,
  input  logic [31:0]      cp0_entry_lo1,
  input  logic [IDX_W-1:0] cp0_wired,
  input  logic             cp0_wired_we,
  output logic [IDX_W-1:0] random,
  output logic [IDX_W-1:0] tlbrw_index,
  output logic             tlbrw_we,
  output tlb_entry_t       tlbrw_wdata,
  input  tlb_entry_t       tlbrw_rdata,
  output logic [31:0]      tlbp_entry_hi,
  input  logic [31:0]      tlbp_index,
  output logic             res_valid,
  output logic             res_index_we,
  output logic [31:0]      res_index,
  output logic             res_entry_we,
  output logic [31:0]      res_entry_hi,
  output logic [31:0]      res_entry_lo0,
  output logic [31:0]      res_entry_lo1,
  output logic             pipe_flush
);

  typedef enum logic [2:0] {StIdle, StRead, StWrite, StProbe, StResp} state_e;

  state_e           state_q, state_d;
  tlb_op_t          op_q, op_in;
  logic             accept, resp;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      hi_q, probe_q;
  tlb_entry_t       wdata_q, rdata_q;

  tlb_random_reg #(
    .TLB_ENTRIES(TLB_ENTRIES),
    .IDX_W      (IDX_W)
  ) u_random (
    .clk     (clk),
    .reset   (reset),
    .wired   (cp0_wired),
    .wired_we(cp0_wired_we),
    .random  (random)
  );

  assign op_in  = tlb_op_t'(op_type);
  assign accept = op_valid && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (op_valid) begin
          case (op_in)
            OpTlbr:          state_d = StRead;
            OpTlbwi, OpTlbwr: state_d = StWrite;
            default:         state_d = StProbe;
          endcase
        end
      end
      StRead, StWrite, StProbe: state_d = StResp;
      default:                  state_d = StIdle;
    endcase
  end

  // TLBWR captures Random in the accept cycle, so a same-cycle Wired write cannot move it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= OpTlbr;
      idx_q   <= '0;
      hi_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      probe_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= op_in;
        idx_q   <= (op_in == OpTlbwr) ? random : cp0_index[IDX_W-1:0];
        hi_q    <= cp0_entry_hi;
        wdata_q <= pack_entry(cp0_entry_hi, cp0_entry_lo0, cp0_entry_lo1);
      end
      if (state_q == StRead) rdata_q <= tlbrw_rdata;
      if (state_q == StProbe) probe_q <= tlbp_index;
    end
  end

  // Strobes are masked by reset so an op aborted mid-flight has no visible effect.
  assign resp          = (state_q == StResp) && !reset;
  assign op_ready      = (state_q == StIdle);
  assign tlbrw_we      = (state_q == StWrite) && !reset;
  assign tlbrw_index   = idx_q;
  assign tlbrw_wdata   = wdata_q;
  assign tlbp_entry_hi = hi_q;

  assign res_valid     = resp;
  assign res_index_we  = resp && (op_q == OpTlbp);
  assign res_entry_we  = resp && (op_q == OpTlbr);
  assign pipe_flush    = resp && (op_q != OpTlbp);
  assign res_index     = probe_q;
  assign res_entry_hi  = hi_word(rdata_q.vpn2, rdata_q.asid);
  assign res_entry_lo0 = lo_word(rdata_q.pfn0, rdata_q.c0, rdata_q.d0, rdata_q.v0, rdata_q.g);
  assign res_entry_lo1 = lo_word(rdata_q.pfn1, rdata_q.c1, rdata_q.d1, rdata_q.v1, rdata_q.g);

  logic unused_index_bits;
  assign unused_index_bits = ^cp0_index[31:IDX_W];

endmodule

// File: tb/tb_tlb_op_unit.sv
// Scoreboarded bench for tlb_op_unit with a small MMU TLB array and a word-level
// reference model of TLB contents, probe results and the Random register.
module tb_tlb_op_unit;
  import cpu_defs::*;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [1:0]  op_type = 2'b00;
  logic        op_ready;
  logic [31:0] cp0_index = '0, cp0_entry_hi = '0, cp0_entry_lo0 = '0, cp0_entry_lo1 = '0;
  logic [3:0]  cp0_wired = '0;
  logic        cp0_wired_we = 1'b0;
  logic [3:0]  random, tlbrw_index;
  logic        tlbrw_we;
  tlb_entry_t  tlbrw_wdata, tlbrw_rdata;
  logic [31:0] tlbp_entry_hi, tlbp_index;
  logic        res_valid, res_index_we, res_entry_we, pipe_flush;
  logic [31:0] res_index, res_entry_hi, res_entry_lo0, res_entry_lo1;

  tlb_op_unit #(.TLB_ENTRIES(N), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_type(op_type), .op_ready(op_ready),
    .cp0_index(cp0_index), .cp0_entry_hi(cp0_entry_hi), .cp0_entry_lo0(cp0_entry_lo0),
    .cp0_entry_lo1(cp0_entry_lo1), .cp0_wired(cp0_wired), .cp0_wired_we(cp0_wired_we),
    .random(random), .tlbrw_index(tlbrw_index), .tlbrw_we(tlbrw_we),
    .tlbrw_wdata(tlbrw_wdata), .tlbrw_rdata(tlbrw_rdata), .tlbp_entry_hi(tlbp_entry_hi),
    .tlbp_index(tlbp_index), .res_valid(res_valid), .res_index_we(res_index_we),
    .res_index(res_index), .res_entry_we(res_entry_we), .res_entry_hi(res_entry_hi),
    .res_entry_lo0(res_entry_lo0), .res_entry_lo1(res_entry_lo1), .pipe_flush(pipe_flush)
  );

  always #5 clk = ~clk;

  // MMU side: TLB storage, combinational read and lowest-index probe.
  tlb_entry_t mmu [N];
  always_comb tlbrw_rdata = mmu[tlbrw_index];
  always_comb begin
    tlbp_index = 32'h8000_0000;
    for (int i = N - 1; i >= 0; i--) begin
      if (mmu[i].vpn2 == tlbp_entry_hi[31:13] &&
          (mmu[i].g || mmu[i].asid == tlbp_entry_hi[7:0])) tlbp_index = 32'(i);
    end
  end
  always @(posedge clk) if (tlbrw_we) mmu[tlbrw_index] <= tlbrw_wdata;

  // Reference model: expected CP0 readback words per entry.
  logic [31:0] ref_hi [N], ref_lo0 [N], ref_lo1 [N];
  int rnd_m = N - 1;
  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset || cp0_wired_we || rnd_m <= int'(cp0_wired) || int'(cp0_wired) >= N - 1)
      rnd_m <= N - 1;
    else
      rnd_m <= rnd_m - 1;
  end

  function automatic logic [31:0] ref_probe(input logic [31:0] key);
    logic [31:0] h;
    for (int i = 0; i < N; i++) begin
      h = ref_hi[i];
      if (h[31:13] == key[31:13] && (ref_lo0[i][0] || h[7:0] == key[7:0])) return 32'(i);
    end
    return 32'h8000_0000;
  endfunction

  typedef struct {
    logic        is_read, is_probe, flush;
    logic [31:0] hi, lo0, lo1, index;
    int          cyc;
  } exp_res_t;
  typedef struct {
    int          idx, cyc;
    logic [31:0] hi;
    logic        g;
  } exp_wr_t;
  exp_res_t rq[$];
  exp_wr_t  wq[$];

  int n_vec = 0, n_err = 0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_res_t r;
      exp_wr_t  w;
      check("random", 32'(random), 32'(rnd_m));
      check("strobe_without_valid",
            32'((res_index_we | res_entry_we | pipe_flush) & ~res_valid), 32'(0));
      if (tlbrw_we) begin
        if (wq.size() == 0) check("unexpected_write", 32'(1), 32'(0));
        else begin
          w = wq.pop_front();
          check("wr_index", 32'(tlbrw_index), 32'(w.idx));
          check("wr_cycle", 32'(cyc), 32'(w.cyc));
          check("wr_vpn2", 32'(tlbrw_wdata.vpn2), 32'(w.hi[31:13]));
          check("wr_asid", 32'(tlbrw_wdata.asid), 32'(w.hi[7:0]));
          check("wr_g", 32'(tlbrw_wdata.g), 32'(w.g));
        end
      end
      if (res_valid) begin
        if (rq.size() == 0) check("unexpected_res", 32'(1), 32'(0));
        else begin
          r = rq.pop_front();
          check("res_cycle", 32'(cyc), 32'(r.cyc));
          check("res_entry_we", 32'(res_entry_we), 32'(r.is_read));
          check("res_index_we", 32'(res_index_we), 32'(r.is_probe));
          check("pipe_flush", 32'(pipe_flush), 32'(r.flush));
          if (r.is_read) begin
            check("rd_hi", res_entry_hi, r.hi);
            check("rd_lo0", res_entry_lo0, r.lo0);
            check("rd_lo1", res_entry_lo1, r.lo1);
          end
          if (r.is_probe) check("probe_index", res_index, r.index);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] idx, input logic [31:0] hi,
                       input logic [31:0] lo0, input logic [31:0] lo1,
                       input logic wwe, input logic [3:0] wval);
    int w = 0;
    int widx;
    exp_res_t r;
    logic g;
    while (!op_ready && w < 20) begin tick(); w++; end
    if (!op_ready) begin check("ready_timeout", 32'(0), 32'(1)); return; end
    op_valid = 1'b1; op_type = op; cp0_index = idx;
    cp0_entry_hi = hi; cp0_entry_lo0 = lo0; cp0_entry_lo1 = lo1;
    if (wwe) begin cp0_wired = wval; cp0_wired_we = 1'b1; end
    widx = (op == 2'b10) ? rnd_m : int'(idx[3:0]);
    if (op == 2'b01 || op == 2'b10) begin
      g = lo0[0] & lo1[0];
      wq.push_back('{idx: widx, cyc: cyc + 1, hi: hi, g: g});
      ref_hi[widx]  = hi & 32'hFFFF_E0FF;
      ref_lo0[widx] = (lo0 & 32'h03FF_FFFE) | 32'(g);
      ref_lo1[widx] = (lo1 & 32'h03FF_FFFE) | 32'(g);
    end
    r.is_read = (op == 2'b00); r.is_probe = (op == 2'b11); r.flush = (op != 2'b11);
    r.hi = ref_hi[widx]; r.lo0 = ref_lo0[widx]; r.lo1 = ref_lo1[widx];
    r.index = ref_probe(hi); r.cyc = cyc + 2;
    rq.push_back(r);
    tick();
    // Junk requests while busy must be ignored.
    cp0_wired_we = 1'b0;
    op_valid = 1'($urandom); op_type = 2'($urandom);
    tick();
    tick();
    op_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_hi();
    return {16'h0, 3'($urandom_range(0, 7)), 13'h0} << 13 >> 13 << 13 |
           {8'h0, 11'($urandom_range(0, 7)), 5'($urandom), 8'($urandom_range(0, 3))};
  endfunction

  initial begin
    int k;
    logic [31:0] h;
    // Reset state.
    tick(); tick();
    #4;
    check("rst_op_ready", 32'(op_ready), 32'(1));
    check("rst_random", 32'(random), 32'(N - 1));
    check("rst_tlbrw_we", 32'(tlbrw_we), 32'(0));
    check("rst_res_valid", 32'(res_valid), 32'(0));
    check("rst_tlbrw_index", 32'(tlbrw_index), 32'(0));
    check("rst_tlbp_entry_hi", tlbp_entry_hi, 32'(0));
    check("rst_wdata_zero", 32'(tlbrw_wdata == '0), 32'(1));
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // Fill every entry with a distinct, non-colliding VPN2.
    for (int i = 0; i < N; i++)
      issue(2'b01, 32'(i), {19'h40000 + 19'(i), 13'h0}, $urandom, $urandom, 1'b0, 4'd0);

    // Directed TLBWI / TLBR / TLBP hit and miss.
    issue(2'b01, 32'hFFFF_FFF5, 32'h0040_2012, 32'h0000_1047, 32'h0000_1087, 1'b0, 4'd0);
    issue(2'b00, 32'd5, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0);
    issue(2'b11, 32'd0, 32'h0040_2012, 32'h0, 32'h0, 1'b0, 4'd0);
    issue(2'b11, 32'd0, {19'h7FFFE, 13'h0}, 32'h0, 32'h0, 1'b0, 4'd0);

    // Wired=4 wrap; monitor follows Random every cycle.
    cp0_wired = 4'd4; cp0_wired_we = 1'b1;
    tick();
    cp0_wired_we = 1'b0;
    repeat (30) tick();

    // TLBWR sampled when Random is 9, with a Wired write in the same cycle.
    k = 0;
    while (rnd_m != 9 && k < 40) begin tick(); k++; end
    issue(2'b10, 32'd0, 32'h1234_5678, $urandom, $urandom, 1'b1, 4'd2);
    issue(2'b00, 32'd9, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0);

    // Reset during WRITE: no strobe, no response, entry 3 untouched.
    op_valid = 1'b1; op_type = 2'b01; cp0_index = 32'd3;
    cp0_entry_hi = 32'hDEAD_B0EF; cp0_entry_lo0 = 32'hFFFF_FFFF; cp0_entry_lo1 = 32'hFFFF_FFFF;
    tick();
    op_valid = 1'b0; reset = 1'b1;
    #4;
    check("abort_tlbrw_we", 32'(tlbrw_we), 32'(0));
    check("abort_res_valid", 32'(res_valid), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_op_ready", 32'(op_ready), 32'(1));
    tick();
    cp0_wired = 4'd0; cp0_wired_we = 1'b1;
    tick();
    cp0_wired_we = 1'b0;
    issue(2'b00, 32'd3, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0);

    // Randomized ops, occasionally with a Wired write in the accept cycle.
    for (int i = 0; i < 200; i++) begin
      h = {16'($urandom_range(0, 7)), 16'h0} << 13 | {16'h0, 3'($urandom), 5'($urandom),
                                                   8'($urandom_range(0, 3))};
      issue(2'($urandom), $urandom, h, $urandom, $urandom,
            ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 10)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) tick();
    end

    repeat (5) tick();
    check("res_queue_drained", 32'(rq.size()), 32'(0));
    check("wr_queue_drained", 32'(wq.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
